// File: rtl/score_keeper.sv
// score_keeper: frame-clocked score engine for the dinosaur runner.
// Sequences IDLE/RUN/PAUSE/OVER, keeps a packed-BCD score, a speed level
// derived from points earned, and a session high score.
module score_keeper #(
  parameter int DIGITS     = 4,
  parameter int PERIOD     = 2,
  parameter int LEVEL_STEP = 100,
  parameter int LEVEL_W    = 4,
  parameter int LEVEL_MAX  = 15
) (
  input  logic                  clk3,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  game_over,
  input  logic                  clear_hi,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_bcd,
  output logic [LEVEL_W-1:0]    level,
  output logic                  level_up,
  output logic                  new_record,
  output logic                  saturated,
  output logic [1:0]            state
);

  localparam int FRAME_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int STEP_W  = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;

  localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(PERIOD - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(LEVEL_STEP - 1);
  localparam logic [LEVEL_W-1:0]  LVL_MAX    = LEVEL_W'(LEVEL_MAX);
  localparam logic [4*DIGITS-1:0] ALL_NINES  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t cur_state, next_state;

  logic [FRAME_W-1:0]  frame_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [4*DIGITS-1:0] score_inc;
  logic                carry;
  logic                active;
  logic                enter_run;
  logic                enter_over;

  assign state      = cur_state;
  assign saturated  = (score_bcd == ALL_NINES);
  assign active     = (cur_state == RUN) && !pause && !game_over;
  assign enter_run  = (cur_state == IDLE) && start;
  assign enter_over = ((cur_state == RUN) || (cur_state == PAUSE)) && game_over;

  // State register, cleared to IDLE by the asynchronous reset.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) cur_state <= IDLE;
    else        cur_state <= next_state;
  end

  // Next-state selection; game_over outranks pause so a collision always ends the run.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:    if (start) next_state = RUN;
      RUN: begin
        if (game_over)  next_state = OVER;
        else if (pause) next_state = PAUSE;
      end
      PAUSE: begin
        if (game_over)   next_state = OVER;
        else if (!pause) next_state = RUN;
      end
      OVER:    if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // BCD ripple increment: each 9 rolls to 0 and passes the carry upward.
  always_comb begin
    score_inc = score_bcd;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (score_bcd[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Frame divider, score, level-step counter and level, all cleared on entry to RUN.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      step_cnt  <= '0;
      score_bcd <= '0;
      level     <= '0;
      level_up  <= 1'b0;
    end else begin
      level_up <= 1'b0;
      if (enter_run) begin
        frame_cnt <= '0;
        step_cnt  <= '0;
        score_bcd <= '0;
        level     <= '0;
      end else if (active) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          if (!saturated) begin
            score_bcd <= score_inc;
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (level != LVL_MAX) begin
                level    <= level + LEVEL_W'(1);
                level_up <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + STEP_W'(1);
            end
          end
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  // High score capture on the edge into OVER, record flag, and IDLE-only clear.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      hi_bcd     <= '0;
      new_record <= 1'b0;
    end else if (enter_over) begin
      if (score_bcd > hi_bcd) begin
        hi_bcd     <= score_bcd;
        new_record <= 1'b1;
      end
    end else if ((cur_state == OVER) && !start) begin
      new_record <= 1'b0;
    end else if ((cur_state == IDLE) && clear_hi) begin
      hi_bcd <= '0;
    end
  end

endmodule
